core_lsu_ooo_tbl: RTL

- Parametrised next-generation load/store unit between IDU and WBU.
- Issues memory requests to the bus master and keeps a request table of configurable depth for both loads and stores.
- Aligns store data into byte lanes with strobes, and sign/zero-extends load data.
- Flags misaligned accesses; registers the writeback output so bus timing is decoupled from WBU.

---
 rtl/core_lsu_ooo_tbl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/core_lsu_ooo_tbl.sv
//------------------------------------------------------------------------------
// Module  : core_lsu_ooo_tbl
// Brief   : Load/store unit with an in-order request table, store lane alignment,
//           load extension and a registered writeback slot.
//           LSU_MISALIGN_CHK_EN enables misaligned-access detection.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core_lsu_ooo_tbl #(
    parameter int OST_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         lsu_rx_valid,
    input  logic [6:0]                   lsu_rx_opcode,
    input  logic [2:0]                   lsu_rx_func3,
    input  logic [XLEN-1:0]              lsu_rx_rs1_data,
    input  logic [XLEN-1:0]              lsu_rx_rs2_data,
    input  logic [4:0]                   lsu_rx_rd_idx,
    input  logic [XLEN-1:0]              lsu_rx_imme,
    output logic                         lsu_rx_ready,
    output logic                         lsu_req_vld,
    output logic                         lsu_req_wen,
    output logic [2:0]                   lsu_req_rwtyp,
    output logic [XLEN-1:0]              lsu_req_addr,
    output logic [XLEN-1:0]              lsu_req_wdata,
    output logic [3:0]                   lsu_req_wstrb,
    input  logic                         lsu_req_rdy,
    input  logic                         lsu_resp_vld,
    input  logic [XLEN-1:0]              lsu_resp_rdata,
    output logic                         lsu_resp_rdy,
    output logic                         lsu_tx_valid,
    output logic [XLEN-1:0]              lsu_tx_data,
    output logic [4:0]                   lsu_tx_rd_idx,
    output logic                         lsu_tx_err,
    input  logic                         lsu_tx_ready,
    output logic [$clog2(OST_DEPTH):0]   lsu_ost_cnt
);

    localparam int         PW       = $clog2(OST_DEPTH);
    localparam int         CW       = PW + 1;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    typedef struct packed {
        logic       is_load;
        logic       bus_issued;
        logic       err;
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] a;
    } ent_t;

    ent_t             tbl_q [OST_DEPTH];
    ent_t             tbl_d [OST_DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tx_valid_q, tx_valid_d;
    logic [XLEN-1:0]  tx_data_q, tx_data_d;
    logic [4:0]       tx_rd_q, tx_rd_d;
    logic             tx_err_q, tx_err_d;

    logic [XLEN-1:0]  eff_addr;
    logic [1:0]       rx_a;
    logic             rx_is_load, rx_mis, full, push, pop;
    logic             head_valid, slot_free, resp_hs, err_retire;
    ent_t             head_ent;
    logic [XLEN-1:0]  rd_shift, rd_ext;

    assign eff_addr   = lsu_rx_rs1_data + lsu_rx_imme;
    assign rx_a       = eff_addr[1:0];
    assign rx_is_load = (lsu_rx_opcode == OPC_LOAD);

`ifdef LSU_MISALIGN_CHK_EN
    assign rx_mis = ((lsu_rx_func3[1:0] == 2'b01) && rx_a[0]) ||
                    ((lsu_rx_func3[1:0] == 2'b10) && (rx_a != 2'b00));
`else
    assign rx_mis = 1'b0;
`endif

    // Misaligned entries bypass the bus, so they only wait for table space.
    assign full         = (cnt_q == CW'(OST_DEPTH));
    assign lsu_req_vld  = lsu_rx_valid && !full && !rx_mis;
    assign lsu_rx_ready = !full && (rx_mis || lsu_req_rdy);
    assign push         = lsu_rx_valid && lsu_rx_ready;

    assign lsu_req_wen   = !rx_is_load;
    assign lsu_req_rwtyp = lsu_rx_func3;
    assign lsu_req_addr  = eff_addr;

    always_comb begin
        lsu_req_wstrb = 4'hF;
        lsu_req_wdata = lsu_rx_rs2_data;
        case (lsu_rx_func3[1:0])
            2'b00: begin
                lsu_req_wstrb = 4'b0001 << rx_a;
                lsu_req_wdata = {4{lsu_rx_rs2_data[7:0]}};
            end
            2'b01: begin
                lsu_req_wstrb = 4'b0011 << rx_a;
                lsu_req_wdata = {2{lsu_rx_rs2_data[15:0]}};
            end
            default: ;
        endcase
        if (rx_is_load) begin
            lsu_req_wstrb = 4'b0000;
        end
    end

    assign head_ent      = tbl_q[head_q];
    assign head_valid    = (cnt_q != '0);
    assign slot_free     = !tx_valid_q || lsu_tx_ready;
    assign lsu_resp_rdy  = head_valid && head_ent.bus_issued && slot_free;
    assign resp_hs       = lsu_resp_vld && lsu_resp_rdy;
    assign err_retire    = head_valid && head_ent.err && slot_free;
    assign pop           = resp_hs || err_retire;

    assign rd_shift = lsu_resp_rdata >> {head_ent.a, 3'b000};

    always_comb begin
        case (head_ent.f3)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  rd_ext = {24'h0, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = lsu_resp_rdata;
        endcase
    end

    always_comb begin
        tbl_d  = tbl_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (push) begin
            tbl_d[tail_q].is_load    = rx_is_load;
            tbl_d[tail_q].bus_issued = !rx_mis;
            tbl_d[tail_q].err        = rx_mis;
            tbl_d[tail_q].rd         = rx_is_load ? lsu_rx_rd_idx : 5'd0;
            tbl_d[tail_q].f3         = lsu_rx_func3;
            tbl_d[tail_q].a          = rx_a;
            tail_d                   = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
    end

    // Stores consume their response without touching the writeback slot.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_rd_d    = tx_rd_q;
        tx_err_d   = tx_err_q;
        if (resp_hs && head_ent.is_load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = rd_ext;
            tx_rd_d    = head_ent.rd;
            tx_err_d   = 1'b0;
        end else if (err_retire) begin
            tx_valid_d = 1'b1;
            tx_data_d  = '0;
            tx_rd_d    = head_ent.rd;
            tx_err_d   = 1'b1;
        end else if (lsu_tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_rd_q    <= '0;
            tx_err_q   <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_rd_q    <= tx_rd_d;
            tx_err_q   <= tx_err_d;
        end
    end

    // Entry payload needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        tbl_q <= tbl_d;
    end

    assign lsu_tx_valid  = tx_valid_q;
    assign lsu_tx_data   = tx_data_q;
    assign lsu_tx_rd_idx = tx_rd_q;
    assign lsu_tx_err    = tx_err_q;
    assign lsu_ost_cnt   = cnt_q;

endmodule

`default_nettype wire
